// File: rtl/axi_rd_responder.sv
// axi_rd_responder: AXI read target returning address-derived INCR bursts after a fixed latency
module axi_rd_responder #(
  parameter int ADDR_LEN     = 32,
  parameter int DATA_LEN     = 64,
  parameter int ID_LEN       = 6,
  parameter int LEN_SIZE     = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 4
) (
  input  logic                clock,
  input  logic                reset,
  output logic                axi_awready,
  output logic                axi_wready,
  output logic [ID_LEN-1:0]   axi_bid,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic [ID_LEN-1:0]   axi_arid,
  input  logic [ADDR_LEN-1:0] axi_araddr,
  input  logic [LEN_SIZE-1:0] axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [ID_LEN-1:0]   axi_rid,
  output logic [DATA_LEN-1:0] axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready,
  output logic [31:0]         burst_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = READ_LATENCY > 0 ? $clog2(READ_LATENCY + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;
  typedef struct packed {
    logic [ID_LEN-1:0]   id;
    logic [ADDR_LEN-1:0] addr;
    logic [LEN_SIZE-1:0] len;
    logic [2:0]          size;
  } req_t;
  req_t mem_q [FIFO_DEPTH];
  req_t head, ar_in, w_q, w_d;
  state_t state_q, state_d;
  logic [PW:0] count_q, count_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic arready_q, arready_d, push, pop;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LEN_SIZE-1:0] idx_q, idx_d, nidx;
  logic rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_LEN-1:0] rid_q, rid_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;
  logic [31:0] bc_q, bc_d;
  logic unused_arburst;
  // Beat 0 keeps the raw address; later beats step from the size-aligned base
  function automatic logic [ADDR_LEN-1:0] beat_addr(input logic [ADDR_LEN-1:0] a,
                                                    input logic [2:0] s,
                                                    input logic [LEN_SIZE-1:0] i);
    logic [ADDR_LEN-1:0] mask;
    mask = (ADDR_LEN'(1) << s) - ADDR_LEN'(1);
    beat_addr = (i == '0) ? a : (a & ~mask) + (ADDR_LEN'(i) << s);
  endfunction
  // Address replicated across the data bus, truncated at the top
  function automatic logic [DATA_LEN-1:0] rep(input logic [ADDR_LEN-1:0] a);
    for (int i = 0; i < DATA_LEN; i++) rep[i] = a[i % ADDR_LEN];
  endfunction
  assign unused_arburst = ^axi_arburst;
  assign ar_in = {axi_arid, axi_araddr, axi_arlen, axi_arsize};
  assign head = mem_q[rp_q];
  assign push = axi_arvalid && arready_q;
  assign nidx = idx_q + LEN_SIZE'(1);
  assign count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  assign wp_d = wp_q + PW'(push);
  assign rp_d = rp_q + PW'(pop);
  assign arready_d = count_d != (PW+1)'(FIFO_DEPTH);
  // Read engine: pop a request, wait out the latency, stream the beats
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    rvalid_d = rvalid_q;
    rlast_d = rlast_q;
    rid_d = rid_q;
    rdata_d = rdata_q;
    bc_d = bc_q;
    pop = 1'b0;
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        pop = 1'b1;
        w_d = head;
        idx_d = '0;
        cnt_d = CW'(READ_LATENCY);
        state_d = READ_LATENCY == 0 ? S_BURST : S_WAIT;
        rvalid_d = READ_LATENCY == 0;
        rlast_d = READ_LATENCY == 0 && head.len == '0;
        rid_d = READ_LATENCY == 0 ? head.id : rid_q;
        rdata_d = READ_LATENCY == 0 ? rep(head.addr) : rdata_q;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_BURST;
          rvalid_d = 1'b1;
          rlast_d = w_q.len == '0;
          rid_d = w_q.id;
          rdata_d = rep(w_q.addr);
        end
      end
      default: if (axi_rready) begin
        state_d = rlast_q ? S_IDLE : S_BURST;
        rvalid_d = !rlast_q;
        rlast_d = !rlast_q && nidx == w_q.len;
        bc_d = rlast_q ? bc_q + 32'd1 : bc_q;
        idx_d = rlast_q ? idx_q : nidx;
        rdata_d = rlast_q ? rdata_q : rep(beat_addr(w_q.addr, w_q.size, nidx));
      end
    endcase
  end
  // Request storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clock) if (push) mem_q[wp_q] <= ar_in;
  // All control state and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      w_q <= '0;
      count_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      arready_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      rvalid_q <= 1'b0;
      rlast_q <= 1'b0;
      rid_q <= '0;
      rdata_q <= '0;
      bc_q <= '0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      count_q <= count_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      arready_q <= arready_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      rvalid_q <= rvalid_d;
      rlast_q <= rlast_d;
      rid_q <= rid_d;
      rdata_q <= rdata_d;
      bc_q <= bc_d;
    end
  end
  assign axi_awready = 1'b0;
  assign axi_wready = 1'b0;
  assign axi_bid = '0;
  assign axi_bresp = 2'b00;
  assign axi_bvalid = 1'b0;
  assign axi_arready = arready_q;
  assign axi_rid = rid_q;
  assign axi_rdata = rdata_q;
  assign axi_rresp = 2'b00;
  assign axi_rlast = rlast_q;
  assign axi_rvalid = rvalid_q;
  assign burst_count = bc_q;
endmodule

// File: tb/tb_axi_rd_responder.sv
// tb_axi_rd_responder: directed self-checking bench for axi_rd_responder
module tb_axi_rd_responder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic awready, wready, bvalid, arready, rlast, rvalid;
  logic [5:0] bid, arid, rid;
  logic [1:0] bresp, rresp;
  logic [31:0] araddr, burst_count;
  logic [3:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid, rready;
  logic [63:0] rdata;
  int tests = 0;
  int fails = 0;

  axi_rd_responder dut (
    .clock(clock), .reset(reset),
    .axi_awready(awready), .axi_wready(wready), .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid),
    .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize), .axi_arburst(arburst),
    .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast), .axi_rvalid(rvalid),
    .axi_rready(rready), .burst_count(burst_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic hs;
    hs = arvalid && arready;
    @(posedge clock);
    #1;
    if (hs) arvalid = 1'b0;
  endtask

  task automatic ar(input logic [5:0] id, input logic [31:0] a, input logic [3:0] l);
    arid = id; araddr = a; arlen = l; arsize = 3'd3; arvalid = 1'b1;
    chk("ar_ready", {63'd0, arready}, 64'd1);
    tick();
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (!rvalid && n < 40) begin
      tick();
      n++;
    end
    chk("rvalid_wait", {63'd0, rvalid}, 64'd1);
  endtask

  initial begin
    logic [31:0] a;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_arready", {63'd0, arready}, 64'd0);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_count", {32'd0, burst_count}, 64'd0);
    chk("tie_off", {58'd0, awready, wready, bvalid, bresp, 1'b0}, 64'd0);
    reset = 1'b1;
    tick();
    chk("arready_after_rst", {63'd0, arready}, 64'd1);
    // single-beat latency: handshake in T, rvalid first in T+6
    ar(6'd3, 32'h100, 4'd0);
    chk("lat_t1", {63'd0, rvalid}, 64'd0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("lat_wait", {63'd0, rvalid}, 64'd0);
    end
    tick();
    chk("lat_t6", {63'd0, rvalid}, 64'd1);
    chk("b1_rid", {58'd0, rid}, 64'd3);
    chk("b1_rdata", rdata, 64'h00000100_00000100);
    chk("b1_rlast", {63'd0, rlast}, 64'd1);
    chk("b1_rresp", {62'd0, rresp}, 64'd0);
    tick();
    chk("b1_done", {63'd0, rvalid}, 64'd0);
    chk("b1_count", {32'd0, burst_count}, 64'd1);
    // four-beat burst from an unaligned start, with a stall on beat 2
    ar(6'd7, 32'h1004, 4'd3);
    wait_rvalid();
    chk("b2_d0", rdata, 64'h00001004_00001004);
    chk("b2_l0", {63'd0, rlast}, 64'd0);
    tick();
    chk("b2_d1", rdata, 64'h00001008_00001008);
    chk("b2_l1", {63'd0, rlast}, 64'd0);
    tick();
    rready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_rvalid", {63'd0, rvalid}, 64'd1);
      chk("stall_rdata", rdata, 64'h00001010_00001010);
      chk("stall_rid", {58'd0, rid}, 64'd7);
      chk("stall_rlast", {63'd0, rlast}, 64'd0);
      tick();
    end
    rready = 1'b1;
    chk("b2_d2", rdata, 64'h00001010_00001010);
    tick();
    chk("b2_d3", rdata, 64'h00001018_00001018);
    chk("b2_l3", {63'd0, rlast}, 64'd1);
    tick();
    chk("b2_done", {63'd0, rvalid}, 64'd0);
    chk("b2_count", {32'd0, burst_count}, 64'd2);
    // address wrap at the top of the address space
    ar(6'd1, 32'hFFFF_FFF8, 4'd1);
    wait_rvalid();
    chk("wrap_d0", rdata, 64'hFFFFFFF8_FFFFFFF8);
    chk("wrap_l0", {63'd0, rlast}, 64'd0);
    tick();
    chk("wrap_d1", rdata, 64'd0);
    chk("wrap_l1", {63'd0, rlast}, 64'd1);
    tick();
    chk("wrap_count", {32'd0, burst_count}, 64'd3);
    // back-to-back requests filling the FIFO while R is stalled
    rready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      arid = 6'(i); araddr = 32'h40 * i; arlen = 4'd0; arsize = 3'd3; arvalid = 1'b1;
      chk("fill_arready", {63'd0, arready}, (i < 5) ? 64'd1 : 64'd0);
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      chk("full_arready", {63'd0, arready}, 64'd0);
      tick();
    end
    rready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_rvalid();
      a = 32'h40 * i;
      chk("order_rid", {58'd0, rid}, 64'(i));
      chk("order_rdata", rdata, {a, a});
      chk("order_rlast", {63'd0, rlast}, 64'd1);
      tick();
    end
    tick();
    chk("order_count", {32'd0, burst_count}, 64'd9);
    chk("order_arvalid_taken", {63'd0, arvalid}, 64'd0);
    // reset in the middle of a burst
    ar(6'd2, 32'h200, 4'd3);
    wait_rvalid();
    tick();
    chk("pre_rst_rvalid", {63'd0, rvalid}, 64'd1);
    reset = 1'b0;
    #1;
    chk("async_rvalid", {63'd0, rvalid}, 64'd0);
    chk("async_count", {32'd0, burst_count}, 64'd0);
    chk("async_arready", {63'd0, arready}, 64'd0);
    #1;
    reset = 1'b1;
    tick();
    chk("post_rst_arready", {63'd0, arready}, 64'd1);
    chk("post_rst_count", {32'd0, burst_count}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      chk("abandoned", {63'd0, rvalid}, 64'd0);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_rd_responder.md
Name: axi_rd_responder

Overview:
- AXI read-side target (subordinate) model, the responder counterpart to the axi_iops read-traffic generator.
- Accepts AR requests into a small request FIFO and waits a fixed, parameterised latency per burst. It then returns INCR bursts whose data is derived deterministically from the beat address.
- Used in simulation and on FPGA as a stand-in memory for IOPS measurement and protocol checking. Write channels are tied off.

Parameters:
- ADDR_LEN, 32: address width.
- DATA_LEN, 64: data width; must be a power of 2, 8..1024.
- ID_LEN, 6: AXI ID width.
- LEN_SIZE, 4: burst length field width (4 = AXI3, 8 = AXI4).
- FIFO_DEPTH, 4: AR request FIFO entries; power of 2, at least 2.
- READ_LATENCY, 4: wait cycles inserted before the first beat of each burst; 0 allowed.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- axi_awready  out  1  tied 0.
- axi_wready  out  1  tied 0.
- axi_bid  out  ID_LEN  tied 0.
- axi_bresp  out  2  tied 0.
- axi_bvalid  out  1  tied 0.
- axi_arid  in  ID_LEN  request ID.
- axi_araddr  in  ADDR_LEN  start address.
- axi_arlen  in  LEN_SIZE  beats minus 1.
- axi_arsize  in  3  log2 bytes per beat; at most log2(DATA_LEN/8).
- axi_arburst  in  2  ignored; always treated as INCR.
- axi_arvalid  in  1  request valid.
- axi_arready  out  1  request accept.
- axi_rid  out  ID_LEN  ID of the burst being returned.
- axi_rdata  out  DATA_LEN  beat data.
- axi_rresp  out  2  always 2'b00 (OKAY).
- axi_rlast  out  1  final beat of the burst.
- axi_rvalid  out  1  beat valid.
- axi_rready  in  1  beat accept.
- burst_count  out  32  completed bursts, wrapping counter.

Behaviour:
- Reset (reset==0, asynchronous): FIFO emptied; state = IDLE; axi_rvalid, axi_rlast, axi_arready, rid, rdata and burst_count all 0. Any in-flight burst is abandoned with no further beats. axi_arready returns to 1 on the first clock edge after reset deasserts.
- AR channel:
  - axi_arready = registered (FIFO count != FIFO_DEPTH).
  - Push on arvalid && arready; stores {arid, araddr, arlen, arsize}.
  - Push and pop in the same cycle are both honoured.
  - When full, arready is 0 and no push occurs, even if a pop happens that cycle. arready rises on the following cycle.
- R engine FSM: IDLE, WAIT, BURST.
  - IDLE: if FIFO non-empty, pop the head into working registers; beat index = 0. If READ_LATENCY == 0, go to BURST; otherwise load the wait counter with READ_LATENCY and go to WAIT.
  - WAIT: decrement the counter; when it reaches 1, go to BURST. WAIT therefore lasts exactly READ_LATENCY cycles.
  - BURST: axi_rvalid = 1. Outputs are stable while axi_rready == 0. On a handshake, the beat index increments.
  - On the handshake of the beat with index == arlen (axi_rlast = 1): burst_count increments and the FSM returns to IDLE, which costs one bubble cycle.
- Latency: an AR handshake in cycle T into an empty FIFO with the engine in IDLE gives the first axi_rvalid in cycle T+2+READ_LATENCY.
- Beat address:
  - Beat 0 = araddr unmodified.
  - Beat i > 0 = (araddr & ~((1<<arsize)-1)) + (i<<arsize).
  - Computed modulo 2^ADDR_LEN (wraps at the address width).
- Beat data: the ADDR_LEN-bit beat address replicated to fill DATA_LEN, truncated at the MSB end if needed. There is no byte-lane shifting for narrow sizes.
- axi_rid = the stored arid for the whole burst.
- axi_rlast = 1 only on beat index == arlen. For arlen == 0, the single beat carries rlast.
- Bursts are returned strictly in acceptance order, with no interleaving.
- Write channels: awready, wready and bvalid are constant 0. AW/W inputs are not present.

Test Plan:
- READ_LATENCY=4, with rready=1: AR id=3, addr=0x100, len=0, size=3 handshaked in cycle T -> rvalid in cycle T+6 only, with rid=3, rdata=0x00000100_00000100, rlast=1; burst_count becomes 1.
- AR addr=0x1004, len=3, size=3 -> four beats with rdata addresses 0x1004, 0x1008, 0x1010, 0x1018; rlast asserted only on the 4th beat.
- Hold rready=0 for 5 cycles mid-burst -> rvalid, rdata, rid and rlast are unchanged throughout; the beat count is unaffected.
- Issue 6 back-to-back ARs (ids 0..5) with FIFO_DEPTH=4 and rready=0 -> 5 accepted, because the engine already holds one burst. arready drops after the 5th is accepted; responses arrive in id order 0..5.
- AR addr=0xFFFFFFF8, len=1, size=3 -> second beat address wraps to 0x00000000.
- Assert reset mid-burst -> rvalid=0 immediately; after release, burst_count=0 and arready=1 on the next edge.
